// File: rtl/trace_collector.sv
// Trace collector: filters the retire stream into a FIFO and emits AXI-Stream style packets.
// Define TRACE_COLLECTOR_TIMESTAMP_EN to prepend a 32-bit capture timestamp to m_tdata.
module trace_collector #(
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int PACKET_LEN  = 8,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = AW + 1,
`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
    localparam int TSW = 32,
`else
    localparam int TSW = 0,
`endif
    localparam int DW = TSW + PC_WIDTH + INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   pc_valid,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   drop_instr,
    output logic [DW-1:0]          m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic [AW:0]            fifo_level,
    output logic                   overflow,
    output logic [15:0]            lost_count,
    output logic                   idle
);

    localparam int CW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam logic [CW-1:0] PKT_MAX  = CW'(PACKET_LEN - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic [CW-1:0]   r_pkt_cnt;
    logic            r_fp;
    logic            r_ovf;
    logic [15:0]     r_lost;

    logic [AW:0]     w_level;
    logic [AW:0]     w_level_nxt;
    logic            w_empty;
    logic            w_full;
    logic            w_push_req;
    logic            w_push;
    logic            w_pop;
    logic            w_lose;
    logic            w_last;
    logic            w_drain_fp;
    logic            w_fp_set;
    logic [DW-1:0]   w_wdata;

`ifdef TRACE_COLLECTOR_TIMESTAMP_EN
    logic [31:0]     r_ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= 32'd0;
        end else begin
            r_ts <= r_ts + 32'd1;
        end
    end

    assign w_wdata = {r_ts, pc, instr};
`else
    assign w_wdata = {pc, instr};
`endif

    assign w_level     = r_wptr - r_rptr;
    assign w_empty     = (w_level == '0);
    assign w_full      = (w_level == FULL_LVL);
    assign w_pop       = !w_empty && m_tready;
    assign w_push_req  = (r_state == S_RUN) && pc_valid && !drop_instr;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_lose      = w_push_req && w_full && !w_pop;
    assign w_level_nxt = w_level + LW'(w_push) - LW'(w_pop);

    assign w_last = !w_empty &&
                    ((r_pkt_cnt == PKT_MAX) ||
                     (r_fp && (w_level == LW'(1))));

    // Early close only matters if something is left to carry the tlast.
    assign w_fp_set = (flush || w_drain_fp) && (w_level_nxt != '0);

    assign m_tdata    = r_mem[r_rptr[AW-1:0]];
    assign m_tvalid   = !w_empty;
    assign m_tlast    = w_last;
    assign fifo_level = w_level;
    assign overflow   = r_ovf;
    assign lost_count = r_lost;
    assign idle       = (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + LW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt <= '0;
            r_fp      <= 1'b0;
        end else begin
            if (w_pop) begin
                if (w_last) begin
                    r_pkt_cnt <= '0;
                end else begin
                    r_pkt_cnt <= r_pkt_cnt + CW'(1);
                end
            end
            if (w_fp_set) begin
                r_fp <= 1'b1;
            end else if (w_pop && w_last) begin
                r_fp <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_lost <= 16'd0;
        end else if (w_lose) begin
            r_ovf <= 1'b1;
            if (r_lost != 16'hFFFF) begin
                r_lost <= r_lost + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_fp  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!en) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_fp  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
